// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: default divisor width and divisor type.
package clk_div_pkg;

    localparam int CLK_DIV_W = 8;

    typedef logic [CLK_DIV_W-1:0] div_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisors, square-wave output and rise tick.
// Divisor updates take effect only on a toggle boundary, on sync, or while the channel is gated off.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               DIV_W   = CLK_DIV_W,
    parameter logic [DIV_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_sync,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_clk_div,
    output logic             o_tick,
    output logic             o_cfg_pend
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pnd_q, pnd_d;
    logic [DIV_W-1:0] nxt_div;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             terminal;

    always_comb begin
        terminal = (cnt_q == act_q);
        // A write landing on a load point goes straight into active and never shows as pending.
        nxt_div  = i_we ? i_div : pnd_q;
        cnt_d    = cnt_q + 1'b1;
        out_d    = out_q;
        tick_d   = 1'b0;
        act_d    = act_q;
        pnd_d    = nxt_div;
        pend_d   = pend_q | i_we;
        if (i_sync || !i_en) begin
            cnt_d  = '0;
            out_d  = 1'b0;
            act_d  = nxt_div;
            pend_d = 1'b0;
        end else if (terminal) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = ~out_q;
            act_d  = nxt_div;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            act_q  <= DIV_RST;
            pnd_q  <= DIV_RST;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pnd_q  <= pnd_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign o_clk_div  = out_q;
    assign o_tick     = tick_q;
    assign o_cfg_pend = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// N-channel programmable clock divider: decodes divisor writes per channel and fans out sync.
// CLK_DIV_GATE_EN adds per-channel enables (i_ch_en) that hold a channel at phase 0 while low.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int                      N_CH     = 2,
    parameter int                      DIV_W    = CLK_DIV_W,
    parameter logic [N_CH*DIV_W-1:0]   DIV_INIT = {8'd216, 8'd24},
    localparam int                     CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_sync,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [DIV_W-1:0] i_cfg_div,
`ifdef CLK_DIV_GATE_EN
    input  logic [N_CH-1:0]  i_ch_en,
`endif
    output logic [N_CH-1:0]  o_clk_div,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_cfg_pend
);

    logic [N_CH-1:0] ch_we;
    logic [N_CH-1:0] ch_en;

`ifdef CLK_DIV_GATE_EN
    assign ch_en = i_ch_en;
`else
    assign ch_en = '1;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        // Channel numbers with no matching instance decode to nothing, so such writes are dropped.
        assign ch_we[k] = i_cfg_we && (i_cfg_ch == CH_W'(k));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_INIT[k*DIV_W +: DIV_W])
        ) u_chan (
            .clk        (clk),
            .i_rst      (i_rst),
            .i_sync     (i_sync),
            .i_en       (ch_en[k]),
            .i_we       (ch_we[k]),
            .i_div      (i_cfg_div),
            .o_clk_div  (o_clk_div[k]),
            .o_tick     (o_tick[k]),
            .o_cfg_pend (o_cfg_pend[k])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed timing checks plus randomized traffic against a half-period model.
// Three channels are used so that an out-of-range channel number is representable on i_cfg_ch.
module tb_clk_div_gen;

    localparam int NCH = 3;
    localparam logic [NCH*8-1:0] INIT = {8'd5, 8'd216, 8'd24};

    logic           clk;
    logic           i_rst;
    logic           i_sync;
    logic           i_cfg_we;
    logic [1:0]     i_cfg_ch;
    logic [7:0]     i_cfg_div;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] o_clk_div;
    logic [NCH-1:0] o_tick;
    logic [NCH-1:0] o_cfg_pend;
    logic [NCH-1:0] en_eff;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    clk_div_gen #(
        .N_CH     (NCH),
        .DIV_W    (8),
        .DIV_INIT (INIT)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_sync     (i_sync),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_ch   (i_cfg_ch),
        .i_cfg_div  (i_cfg_div),
`ifdef CLK_DIV_GATE_EN
        .i_ch_en    (ch_en),
`endif
        .o_clk_div  (o_clk_div),
        .o_tick     (o_tick),
        .o_cfg_pend (o_cfg_pend)
    );

`ifdef CLK_DIV_GATE_EN
    assign en_eff = ch_en;
`else
    assign en_eff = '1;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each channel waits 'half' cycles between toggles; divisor changes
    // are applied only where a half-period closes, on sync, or while gated.
    int             m_el   [NCH];
    int             m_half [NCH];
    int             m_pv   [NCH];
    bit [NCH-1:0]   m_lvl, m_tick, m_pend;
    bit             m_ready = 1'b0;

    function automatic int init_div(input int k);
        return int'(INIT[k*8 +: 8]);
    endfunction

    function automatic bit wr(input int k);
        return i_cfg_we && (int'(i_cfg_ch) == k);
    endfunction

    function automatic int next_div(input int k);
        return wr(k) ? int'(i_cfg_div) : m_pv[k];
    endfunction

    always @(posedge clk) begin
        m_ready <= 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (i_rst) begin
                m_el[k]   <= 0;
                m_lvl[k]  <= 1'b0;
                m_tick[k] <= 1'b0;
                m_pend[k] <= 1'b0;
                m_half[k] <= init_div(k) + 1;
                m_pv[k]   <= init_div(k);
            end else begin
                if (wr(k)) m_pv[k] <= int'(i_cfg_div);
                if (i_sync || !en_eff[k]) begin
                    m_el[k]   <= 0;
                    m_lvl[k]  <= 1'b0;
                    m_tick[k] <= 1'b0;
                    m_pend[k] <= 1'b0;
                    m_half[k] <= next_div(k) + 1;
                end else if (m_el[k] + 1 == m_half[k]) begin
                    m_lvl[k]  <= !m_lvl[k];
                    m_tick[k] <= !m_lvl[k];
                    m_el[k]   <= 0;
                    m_pend[k] <= 1'b0;
                    m_half[k] <= next_div(k) + 1;
                end else begin
                    m_el[k]   <= m_el[k] + 1;
                    m_tick[k] <= 1'b0;
                    if (wr(k)) m_pend[k] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_clk_div", 32'(o_clk_div), 32'(m_lvl));
            chk("model_tick", 32'(o_tick), 32'(m_tick));
            chk("model_pend", 32'(o_cfg_pend), 32'(m_pend));
        end
    end

    task automatic wait_tick(input int k, input int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (o_tick[k]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            chk("tick_timeout", 0, 1);
            t = cyc;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, t0, t1, s, hi, tp;
        i_rst = 1'b1; i_sync = 1'b0; i_cfg_we = 1'b0;
        i_cfg_ch = '0; i_cfg_div = '0; ch_en = '1;
        repeat (3) @(negedge clk);
        chk("rst_clk_div", 32'(o_clk_div), 0);
        chk("rst_tick", 32'(o_tick), 0);
        chk("rst_pend", 32'(o_cfg_pend), 0);
        chk("model_rst_half1", m_half[1], 217);

        // Defaults: ch0 half 25, ch1 half 217.
        i_rst = 1'b0; rel = cyc;
        wait_tick(0, 100, t0);  chk("ch0_first_rise", t0 - rel, 25);
        wait_tick(0, 100, t1);  chk("ch0_period", t1 - t0, 50);
        wait_tick(1, 500, t0);  chk("ch1_first_rise", t0 - rel, 217);
        wait_tick(1, 600, t1);  chk("ch1_period", t1 - t0, 434);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_clk_div[0]) hi++;
        end
        chk("ch0_duty_high", hi, 25);

        // Divisor 3 written mid half-period on ch0.
        wait_tick(0, 100, t0);
        repeat (10) @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_div = 8'd3;
        @(negedge clk);
        i_cfg_we = 1'b0;
        chk("wr_pend0_set", 32'(o_cfg_pend[0]), 1);
        chk("wr_pend1_clear", 32'(o_cfg_pend[1]), 0);
        s = -1;
        for (int i = 0; i < 40; i++) begin
            if (!o_cfg_pend[0]) begin s = cyc; break; end
            @(negedge clk);
        end
        chk("wr_pend0_clear_at", s - t0, 25);
        wait_tick(0, 100, t1);  chk("wr_new_first_rise", t1 - t0, 29);
        wait_tick(0, 100, tp);  chk("wr_new_period", tp - t1, 8);
        chk("model_half0", m_half[0], 4);

        // Divisor 0 written on the exact terminal cycle.
        wait_tick(0, 100, t0);
        repeat (3) @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_div = 8'd0;
        for (int i = 4; i <= 10; i++) begin
            @(negedge clk);
            i_cfg_we = 1'b0;
            chk("term_wr_clk", 32'(o_clk_div[0]), 32'(i % 2));
            chk("term_wr_pend", 32'(o_cfg_pend[0]), 0);
        end

        // Pending write on ch1, then sync.
        wait_tick(1, 600, t0);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd1; i_cfg_div = 8'd9;
        @(negedge clk);
        i_cfg_we = 1'b0;
        chk("sync_pend1_set", 32'(o_cfg_pend[1]), 1);
        i_sync = 1'b1;
        @(negedge clk);
        i_sync = 1'b0; s = cyc;
        chk("sync_clk_zero", 32'(o_clk_div), 0);
        chk("sync_pend_zero", 32'(o_cfg_pend), 0);
        wait_tick(1, 100, t0);  chk("sync_ch1_first_rise", t0 - s, 10);
        wait_tick(1, 100, t1);  chk("sync_ch1_period", t1 - t0, 20);

        // Out-of-range channel write, then reset mid-period.
        @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd3; i_cfg_div = 8'd77;
        @(negedge clk);
        i_cfg_we = 1'b0;
        chk("bad_ch_pend", 32'(o_cfg_pend), 0);
        repeat (7) @(negedge clk);
        i_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_outputs", {29'd0, o_clk_div | o_tick | o_cfg_pend}, 0);
        end
        i_rst = 1'b0; rel = cyc;
        wait_tick(2, 50, t0);   chk("rst_ch2_first_rise", t0 - rel, 6);
        wait_tick(0, 100, t0);  chk("rst_ch0_first_rise", t0 - rel, 25);
        wait_tick(1, 500, t0);  chk("rst_ch1_first_rise", t0 - rel, 217);

`ifdef CLK_DIV_GATE_EN
        ch_en[1] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("gate_held", {30'd0, o_clk_div[1], o_tick[1]}, 0);
        end
        ch_en[1] = 1'b1; s = cyc;
        wait_tick(1, 400, t0);  chk("gate_first_rise", t0 - s, 217);
`endif

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            i_rst     = ($urandom_range(0, 999) == 0);
            i_sync    = ($urandom_range(0, 199) == 0);
            i_cfg_we  = ($urandom_range(0, 7) == 0);
            i_cfg_ch  = 2'($urandom_range(0, 3));
            i_cfg_div = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 12));
`ifdef CLK_DIV_GATE_EN
            if ($urandom_range(0, 63) == 0) begin
                int c;
                c = int'($urandom_range(0, NCH - 1));
                ch_en[c] = ~ch_en[c];
            end
`endif
        end
        @(negedge clk);
        i_rst = 1'b0; i_sync = 1'b0; i_cfg_we = 1'b0; ch_en = '1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
